// File: rtl/fwd_pkg.sv
// Shared constants and entry type for the forwarding pipeline.
// Default widths of the top level are taken from here.
package fwd_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [REG_AW-1:0] dst;
        logic [DATA_W-1:0] data;
    } stage_entry_t;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline slot: loads from upstream when advancing, otherwise holds.
// Flush clears only the valid bit; payload is don't-care once invalid.
module pipe_stage #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv_i,
    input  logic         up_valid_i,
    input  logic [W-1:0] up_payload_i,
    input  logic         flush_i,
    output logic         valid_o,
    output logic         valid_next_o,
    output logic [W-1:0] payload_o
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] payload_q;
    logic [W-1:0] payload_d;

    // Next-state: an entry arriving this edge is discarded by a flush of this slot.
    always_comb begin
        valid_d   = (adv_i ? up_valid_i : valid_q) & ~flush_i;
        payload_d = (adv_i && up_valid_i) ? up_payload_i : payload_q;
    end

    // Slot register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign valid_o      = valid_q;
    assign valid_next_o = valid_d;
    assign payload_o    = payload_q;

endmodule

// File: rtl/fwd_pipe.sv
// Elastic result pipeline with per-stage flush and register-forwarding lookup.
// Stage 0 is youngest; the oldest stage drives the output handshake.
module fwd_pipe
    import fwd_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int STAGES = 3,
    parameter int AW     = REG_AW,
    parameter int NRD    = 2,
    localparam int SW    = (STAGES > 1) ? $clog2(STAGES) : 1,
    localparam int OW    = $clog2(STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [AW-1:0]        in_dst,
    input  logic                 in_wr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [AW-1:0]        out_dst,
    output logic                 out_wr,
    input  logic [STAGES-1:0]    flush,
    input  logic [NRD*AW-1:0]    qry_addr,
    output logic [NRD-1:0]       qry_hit,
    output logic [NRD*WIDTH-1:0] qry_data,
    output logic [NRD*SW-1:0]    qry_stage,
    output logic [OW-1:0]        occupancy
);

    typedef struct packed {
        logic             wr;
        logic [AW-1:0]    dst;
        logic [WIDTH-1:0] data;
    } entry_t;

    localparam int EW = $bits(entry_t);

    logic [STAGES-1:0] valid_s;
    logic [STAGES-1:0] valid_next_s;
    logic [STAGES-1:0] adv_s;
    entry_t            stage_s [STAGES];
    entry_t            in_entry_s;
    logic [OW-1:0]     occupancy_q;
    logic [OW-1:0]     occupancy_d;

    assign in_entry_s = '{wr: in_wr, dst: in_dst, data: in_data};

    // A stage moves when it is empty or every older stage is able to move.
    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic          up_valid_s;
            logic [EW-1:0] up_payload_s;
            logic [EW-1:0] payload_s;

            assign adv_s[k] = out_ready | ~(&valid_s[STAGES-1:k]);

            if (k == 0) begin : g_head
                assign up_valid_s   = in_valid;
                assign up_payload_s = in_entry_s;
            end else begin : g_body
                assign up_valid_s   = valid_s[k-1];
                assign up_payload_s = stage_s[k-1];
            end

            pipe_stage #(.W(EW)) u_stage (
                .clk          (clk),
                .rst          (rst),
                .adv_i        (adv_s[k]),
                .up_valid_i   (up_valid_s),
                .up_payload_i (up_payload_s),
                .flush_i      (flush[k]),
                .valid_o      (valid_s[k]),
                .valid_next_o (valid_next_s[k]),
                .payload_o    (payload_s)
            );

            assign stage_s[k] = entry_t'(payload_s);
        end
    endgenerate

    assign in_ready  = adv_s[0];
    assign out_valid = valid_s[STAGES-1];
    assign out_data  = stage_s[STAGES-1].data;
    assign out_dst   = stage_s[STAGES-1].dst;
    assign out_wr    = stage_s[STAGES-1].wr;

    // Forwarding search: scan oldest to youngest so the youngest match overrides.
    genvar p;
    generate
        for (p = 0; p < NRD; p++) begin : g_qry
            logic [AW-1:0]    addr_s;
            logic             hit_s;
            logic [WIDTH-1:0] data_s;
            logic [SW-1:0]    stg_s;
            logic             match_s;

            assign addr_s = qry_addr[p*AW +: AW];

            // Priority match across all stages for this query port.
            always_comb begin
                hit_s   = 1'b0;
                data_s  = '0;
                stg_s   = '0;
                match_s = 1'b0;
                for (int s = STAGES - 1; s >= 0; s--) begin
                    match_s = valid_s[s] && stage_s[s].wr &&
                              (stage_s[s].dst == addr_s) &&
                              (addr_s != AW'(ZERO_REG));
                    hit_s   = hit_s | match_s;
                    data_s  = match_s ? stage_s[s].data : data_s;
                    stg_s   = match_s ? SW'(s) : stg_s;
                end
            end

            assign qry_hit[p]              = hit_s;
            assign qry_data[p*WIDTH +: WIDTH] = data_s;
            assign qry_stage[p*SW +: SW]   = stg_s;
        end
    endgenerate

    // Population count of the valid bits that will hold after this edge.
    always_comb begin
        occupancy_d = '0;
        for (int s = 0; s < STAGES; s++) begin
            occupancy_d = occupancy_d + OW'(valid_next_s[s]);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy_q <= '0;
        end else begin
            occupancy_q <= occupancy_d;
        end
    end

    assign occupancy = occupancy_q;

endmodule

// File: tb/tb_fwd_pipe.sv
// Directed bench for fwd_pipe (defaults: WIDTH=32, STAGES=3, AW=5, NRD=2).
module tb_fwd_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_dst;
    logic        in_wr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_dst;
    logic        out_wr;
    logic [2:0]  flush;
    logic [9:0]  qry_addr;
    logic [1:0]  qry_hit;
    logic [63:0] qry_data;
    logic [3:0]  qry_stage;
    logic [1:0]  occupancy;

    int checks_q = 0;
    int fails_q  = 0;

    always #5 clk = ~clk;

    fwd_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dst    (in_dst),
        .in_wr     (in_wr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dst   (out_dst),
        .out_wr    (out_wr),
        .flush     (flush),
        .qry_addr  (qry_addr),
        .qry_hit   (qry_hit),
        .qry_data  (qry_data),
        .qry_stage (qry_stage),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_q++;
        if (obs !== exp) begin
            fails_q++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [4:0] d, input logic w, input logic [31:0] x);
        in_valid = v;
        in_dst   = d;
        in_wr    = w;
        in_data  = x;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        out_ready = 1'b0;
        flush     = 3'b000;
        qry_addr  = 10'd0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_occ", 64'(occupancy), 64'd0);

        // Back-to-back 0x11,0x22,0x33 with out_ready high
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 5'd1, 1'b1, 32'h11);
        cyc;
        chk("lat_e1_valid", 64'(out_valid), 64'd0);
        chk("lat_e1_occ", 64'(occupancy), 64'd1);
        drive(1'b1, 5'd2, 1'b1, 32'h22);
        cyc;
        chk("lat_e2_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 5'd3, 1'b1, 32'h33);
        cyc;
        chk("lat_e3_valid", 64'(out_valid), 64'd1);
        chk("lat_e3_data", 64'(out_data), 64'h11);
        chk("lat_e3_occ", 64'(occupancy), 64'd3);
        chk("lat_e3_ready", 64'(in_ready), 64'd1);
        qry_addr = {5'd1, 5'd2};
        #1;
        chk("qry_mid_hit", 64'(qry_hit), 64'b11);
        chk("qry_mid_data", qry_data, {32'h11, 32'h22});
        chk("qry_mid_stage", 64'(qry_stage), 64'b1001);
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        cyc;
        chk("stream_d2", 64'(out_data), 64'h22);
        chk("stream_v2", 64'(out_valid), 64'd1);
        cyc;
        chk("stream_d3", 64'(out_data), 64'h33);
        chk("stream_occ1", 64'(occupancy), 64'd1);
        cyc;
        chk("stream_empty", 64'(out_valid), 64'd0);
        chk("stream_occ0", 64'(occupancy), 64'd0);

        // Fill with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 5'd5, 1'b1, 32'hBB);
        cyc;
        chk("fill_occ1", 64'(occupancy), 64'd1);
        drive(1'b1, 5'd7, 1'b0, 32'hCC);
        cyc;
        chk("fill_occ2", 64'(occupancy), 64'd2);
        chk("fill_ready2", 64'(in_ready), 64'd1);
        drive(1'b1, 5'd5, 1'b1, 32'hAA);
        cyc;
        chk("fill_occ3", 64'(occupancy), 64'd3);
        chk("fill_ready3", 64'(in_ready), 64'd0);
        chk("fill_out", 64'(out_data), 64'hBB);
        chk("fill_dst", 64'(out_dst), 64'd5);
        qry_addr = {5'd7, 5'd5};
        #1;
        chk("qry_prio_hit", 64'(qry_hit), 64'b01);
        chk("qry_prio_data", qry_data, {32'h0, 32'hAA});
        chk("qry_prio_stage", 64'(qry_stage), 64'd0);
        qry_addr = {5'd3, 5'd5};
        #1;
        chk("qry_nomatch_hit", 64'(qry_hit[1]), 64'd0);
        drive(1'b1, 5'd9, 1'b1, 32'hDD);
        cyc;
        chk("hold_occ", 64'(occupancy), 64'd3);
        chk("hold_data", 64'(out_data), 64'hBB);
        chk("hold_wr", 64'(out_wr), 64'd1);

        // Flush the two youngest stages while full
        flush = 3'b011;
        drive(1'b1, 5'd9, 1'b1, 32'hEE);
        cyc;
        chk("flush_occ", 64'(occupancy), 64'd1);
        chk("flush_out", 64'(out_data), 64'hBB);
        chk("flush_ready", 64'(in_ready), 64'd1);
        qry_addr = {5'd9, 5'd5};
        #1;
        chk("flush_qry_hit", 64'(qry_hit), 64'b01);
        chk("flush_qry_stage", 64'(qry_stage[1:0]), 64'd2);
        flush = 3'b000;
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        out_ready = 1'b1;
        cyc;
        chk("flush_drain_v", 64'(out_valid), 64'd0);
        chk("flush_drain_occ", 64'(occupancy), 64'd0);

        // Flush all stages with an incoming entry
        drive(1'b1, 5'd1, 1'b1, 32'hF1);
        cyc;
        drive(1'b1, 5'd1, 1'b1, 32'hF2);
        cyc;
        chk("fall_pre_occ", 64'(occupancy), 64'd2);
        drive(1'b1, 5'd1, 1'b1, 32'hF3);
        flush = 3'b111;
        cyc;
        chk("fall_occ", 64'(occupancy), 64'd0);
        chk("fall_valid", 64'(out_valid), 64'd0);
        flush = 3'b000;
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc;
            chk("fall_quiet", 64'(out_valid), 64'd0);
        end

        // Reset mid-stream with two entries in flight
        drive(1'b1, 5'd0, 1'b1, 32'h55);
        cyc;
        drive(1'b1, 5'd9, 1'b1, 32'h66);
        cyc;
        chk("mid_occ2", 64'(occupancy), 64'd2);
        qry_addr = {5'd9, 5'd0};
        #1;
        chk("qry_zero_hit", 64'(qry_hit), 64'b10);
        chk("qry_zero_data", qry_data, {32'h66, 32'h0});
        chk("qry_p1_stage", 64'(qry_stage[3:2]), 64'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_occ", 64'(occupancy), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_qry", 64'(qry_hit), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 5'd4, 1'b1, 32'h77);
        cyc;
        chk("post_occ1", 64'(occupancy), 64'd1);
        chk("post_v1", 64'(out_valid), 64'd0);
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        cyc;
        chk("post_v2", 64'(out_valid), 64'd0);
        cyc;
        chk("post_v3", 64'(out_valid), 64'd1);
        chk("post_data", 64'(out_data), 64'h77);
        cyc;
        chk("post_empty", 64'(out_valid), 64'd0);
        chk("post_occ0", 64'(occupancy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_q, fails_q);
        $finish;
    end

endmodule

// File: doc/fwd_pipe.md
FWD_PIPE -- requirements
Module: fwd_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data bits per entry.
REQ-002 Parameter STAGES, default 3, pipeline depth (legal range 1..8).
REQ-003 Parameter AW, default 5, register-address width.
REQ-004 Parameter NRD, default 2, number of forwarding query ports.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1; in_ready  out  1: upstream handshake, accepted when both high.
REQ-008 in_data  in  WIDTH; in_dst  in  AW; in_wr  in  1: result, destination register, register-write flag.
REQ-009 out_valid  out  1; out_ready  in  1: downstream handshake, delivered when both high.
REQ-010 out_data  out  WIDTH; out_dst  out  AW; out_wr  out  1: oldest entry's fields.
REQ-011 flush  in  STAGES: bit k invalidates stage k (stage 0 youngest).
REQ-012 qry_addr  in  NRD*AW; qry_hit  out  NRD; qry_data  out  NRD*WIDTH; qry_stage  out  NRD*clog2(STAGES): forwarding lookup.
REQ-013 occupancy  out  clog2(STAGES+1): registered count of valid stages.

Function
REQ-014 Each stage holds {valid, wr, dst, data}; stage STAGES-1 drives out_*.
REQ-015 Stage STAGES-1 advances when out_ready or not valid; stage k<STAGES-1 advances when stage k+1 advances or stage k is not valid.
REQ-016 in_ready equals the stage-0 advance condition, combinational from out_ready and valid bits only (not from in_valid).
REQ-017 Sustained throughput one entry per cycle; latency STAGES cycles from acceptance to out_valid with out_ready held high.
REQ-018 Holding stage keeps all fields unchanged; out_data/out_dst/out_wr stable while out_valid high and out_ready low.
REQ-019 flush[k] at an edge clears stage k valid; an entry moving into stage k that edge is discarded; the entry leaving stage k that edge proceeds normally.
REQ-020 Simultaneous flush of all stages with in_valid: incoming entry discarded, pipeline empty next cycle.
REQ-021 Query port p hits when some stage is valid, wr=1, dst==qry_addr[p], and qry_addr[p]!=0.
REQ-022 Multiple matches: youngest (lowest index) stage wins; qry_stage gives its index; qry_data its data.
REQ-023 No hit: qry_hit=0, qry_data=0, qry_stage=0.
REQ-024 Query outputs are combinational from current stage contents, same-cycle.
REQ-025 occupancy updates each edge to the number of valid stages after that edge; never exceeds STAGES.

Reset
REQ-026 rst low: all valid bits, data, dst, wr and occupancy clear to 0 immediately; out_valid=0, in_ready=1.
REQ-027 Reset mid-transfer discards all entries; no entry is delivered after rst rises unless accepted after release.
REQ-028 First acceptance possible on the first rising edge with rst high.

Structure
REQ-029 Shared package fwd_pkg holds DATA_W=32, REG_AW=5, ZERO_REG=0 constants and the stage-entry struct typedef.
REQ-030 One sub-module pipe_stage (single entry register with load, hold, flush) instantiated STAGES times via generate.
REQ-031 Forwarding priority search is a generate loop inside fwd_pipe, not a separate module.

Verification
REQ-032 Reset, then push 0x11,0x22,0x33 back-to-back with out_ready=1 -> out_valid first high 3 cycles after first accept, data 0x11,0x22,0x33 on consecutive cycles.
REQ-033 Fill pipeline with out_ready=0 -> in_ready low after 3 accepts, occupancy=3, out_data held at first entry until out_ready rises.
REQ-034 Stage0 {dst=5,wr=1,data=0xAA}, stage2 {dst=5,wr=1,data=0xBB}, qry_addr=5 -> qry_hit=1, qry_data=0xAA, qry_stage=0; qry_addr=0 with dst=0 entry -> qry_hit=0.
REQ-035 Entry with wr=0, dst=7, query 7 -> qry_hit=0, qry_data=0.
REQ-036 Full pipeline, flush=3'b011 with in_valid=1 -> only stage-2 entry survives, occupancy=1, incoming discarded.
REQ-037 Assert rst mid-stream with 2 entries -> out_valid=0, occupancy=0 immediately; no stale entry emerges after release.
